// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS pattern transmitter.
// Holds the pattern modes, LFSR taps, active lengths and the feedback/mask helpers.
package prbs_pkg;

  localparam int unsigned LFSR_W = 31;

  typedef enum logic [1:0] {
    MODE_PRBS7  = 2'd0,
    MODE_PRBS15 = 2'd1,
    MODE_PRBS31 = 2'd2,
    MODE_FIXED  = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0] t1;
    logic [4:0] t2;
  } taps_t;

  localparam taps_t TAPS_PRBS7  = '{t1: 5'd6,  t2: 5'd5};
  localparam taps_t TAPS_PRBS15 = '{t1: 5'd14, t2: 5'd13};
  localparam taps_t TAPS_PRBS31 = '{t1: 5'd30, t2: 5'd27};

  localparam int unsigned LEN_PRBS7  = 7;
  localparam int unsigned LEN_PRBS15 = 15;
  localparam int unsigned LEN_PRBS31 = 31;

  // Bits of the shared state that the selected polynomial actually uses.
  function automatic logic [LFSR_W-1:0] active_mask(input mode_e m);
    int unsigned len;
    logic [LFSR_W-1:0] mask;
    case (m)
      MODE_PRBS7:  len = LEN_PRBS7;
      MODE_PRBS15: len = LEN_PRBS15;
      default:     len = LEN_PRBS31;
    endcase
    mask = '0;
    for (int unsigned i = 0; i < LFSR_W; i++) begin
      if (i < len) mask[i] = 1'b1;
    end
    return mask;
  endfunction

  // Constant tap indices per branch keep this a small mux rather than a barrel select.
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s, input mode_e m);
    logic fb;
    case (m)
      MODE_PRBS7:  fb = s[TAPS_PRBS7.t1]  ^ s[TAPS_PRBS7.t2];
      MODE_PRBS15: fb = s[TAPS_PRBS15.t1] ^ s[TAPS_PRBS15.t2];
      default:     fb = s[TAPS_PRBS31.t1] ^ s[TAPS_PRBS31.t2];
    endcase
    return fb;
  endfunction

endpackage

// File: rtl/prbs_pattern_tx_word_gen.sv
// Combinational word generator: WIDTH unrolled LFSR steps or the fixed word,
// plus the next LFSR state including the all-zero lock-up reseed.
module prbs_word_gen
  import prbs_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [LFSR_W-1:0] i_state,
  input  mode_e             i_mode,
  input  logic [WIDTH-1:0]  i_fixed_word,
  output logic [WIDTH-1:0]  o_word,
  output logic [LFSR_W-1:0] o_next_state
);

  logic [LFSR_W-1:0] w_mask;
  logic [LFSR_W-1:0] w_seed;
  logic [LFSR_W-1:0] w_s;
  logic [WIDTH-1:0]  w_bits;
  logic              w_fb;

  always_comb begin
    w_mask = active_mask(i_mode);
    w_seed = i_state;
    if ((i_state & w_mask) == '0) w_seed = i_state | w_mask;

    w_s    = w_seed;
    w_bits = '0;
    w_fb   = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_fb      = lfsr_fb(w_s, i_mode);
      w_bits[i] = w_fb;
      w_s       = {w_s[LFSR_W-2:0], w_fb};
    end

    if (i_mode == MODE_FIXED) begin
      o_word       = i_fixed_word;
      o_next_state = i_state;
    end else begin
      o_word       = w_bits;
      o_next_state = w_s;
    end
  end

endmodule

// File: rtl/prbs_pattern_tx.sv
// Single-clock PRBS/fixed-pattern serial transmitter with word framing,
// one-shot error injection and a wrapping word counter.
module prbs_pattern_tx
  import prbs_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_fixed_word,
  input  logic             i_inject_err,
  output logic             o_ser_out,
  output logic             o_word_strobe,
  output logic             o_err_injected,
  output logic             o_busy,
  output logic [15:0]      o_word_cnt
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [LFSR_W-1:0] r_lfsr;
  logic [WIDTH-1:0]  r_sreg;
  logic              r_pending;
  logic              r_ser;
  logic              r_strobe;
  logic              r_err;
  logic              r_busy;
  logic [15:0]       r_word_cnt;

  logic [WIDTH-1:0]  w_word;
  logic [LFSR_W-1:0] w_next;
  logic              w_last;
  logic              w_load;

  prbs_word_gen #(.WIDTH(WIDTH)) u_word_gen (
    .i_state      (r_lfsr),
    .i_mode       (mode_e'(i_mode)),
    .i_fixed_word (i_fixed_word),
    .o_word       (w_word),
    .o_next_state (w_next)
  );

  assign w_last = (r_state == ST_RUN) && (r_cnt == LAST_BIT);
  assign w_load = i_en && ((r_state == ST_IDLE) || w_last);

  // r_sreg holds only the bits not yet on ser_out, so ser_out stays a plain register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_lfsr     <= '1;
      r_sreg     <= '0;
      r_pending  <= 1'b0;
      r_ser      <= 1'b0;
      r_strobe   <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_strobe <= 1'b0;
      r_err    <= 1'b0;
      if (i_inject_err) r_pending <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          r_ser  <= 1'b0;
          r_cnt  <= '0;
          r_sreg <= '0;
        end
        ST_RUN: begin
          if (!w_last) begin
            r_ser  <= r_sreg[0];
            r_sreg <= r_sreg >> 1;
            r_cnt  <= r_cnt + CNT_W'(1);
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_ser   <= 1'b0;
            r_sreg  <= '0;
            r_cnt   <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A load overrides the per-state updates above; a pulse coinciding with it stays pending.
      if (w_load) begin
        r_state    <= ST_RUN;
        r_busy     <= 1'b1;
        r_cnt      <= '0;
        r_lfsr     <= w_next;
        r_sreg     <= w_word >> 1;
        r_ser      <= w_word[0] ^ r_pending;
        r_err      <= r_pending;
        r_strobe   <= 1'b1;
        r_pending  <= i_inject_err;
        r_word_cnt <= r_word_cnt + 16'd1;
      end
    end
  end

  assign o_ser_out      = r_ser;
  assign o_word_strobe  = r_strobe;
  assign o_err_injected = r_err;
  assign o_busy         = r_busy;
  assign o_word_cnt     = r_word_cnt;

endmodule
